// File: rtl/feed_forward_node_for_input_layer.sv
// Pipelined single-precision dot-product node (register, multiply, accumulate, activate).
// Optional macro FF_NODE_OVERFLOW_FLAG_EN adds the o_overflow status output.
module feed_forward_node_for_input_layer #(
    parameter int          DATA_WIDTH           = 32,
    parameter int          NUMBER_OF_INPUT_NODE = 33,
    parameter logic        LEAKYRELU_ENABLE     = 1'b1,
    parameter logic [31:0] ALPHA                = 32'h3DCCCCCD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_weight,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
`ifdef FF_NODE_OVERFLOW_FLAG_EN
    output logic                  o_overflow,
`endif
    output logic                  o_valid
);

    localparam logic [31:0] QNAN  = 32'h7FC00000;
    localparam int          CNT_W = (NUMBER_OF_INPUT_NODE > 1) ? $clog2(NUMBER_OF_INPUT_NODE) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUMBER_OF_INPUT_NODE - 1);

    function automatic logic is_nan(input logic [31:0] x);
        is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s, a_zero, b_zero, a_inf, b_inf, g, st;
        logic [47:0]        p;
        logic [23:0]        m;
        logic [24:0]        r;
        logic signed [10:0] e;
        s      = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        p      = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e      = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 11'sd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        r = {1'b0, m} + {24'd0, g & (st | m[0])};
        if (r[24]) begin
            r = r >> 1;
            e = e + 11'sd1;
        end
        if (is_nan(a) || is_nan(b) || (a_inf && b_zero) || (b_inf && a_zero))
            fp_mul = QNAN;
        else if (a_inf || b_inf)
            fp_mul = {s, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            fp_mul = {s, 31'd0};
        else if (e >= 11'sd255)
            fp_mul = {s, 8'hFF, 23'd0};
        else if (e <= 11'sd0)
            fp_mul = {s, 31'd0};
        else
            fp_mul = {s, e[7:0], r[22:0]};
    endfunction

    // Guard/round/sticky adder; x always carries the larger magnitude so the difference is non-negative.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [7:0]         d;
        logic [26:0]        lx, sx, ys, mask, m;
        logic [27:0]        sum;
        logic [4:0]         lz;
        logic [24:0]        r;
        logic               found, a_inf, b_inf;
        logic signed [10:0] e;
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        lx = {1'b1, x[22:0], 3'b0};
        ys = {1'b1, y[22:0], 3'b0};
        if (d >= 8'd27) begin
            sx = 27'd1;
        end else begin
            mask  = ~(27'h7FFFFFF << d);
            sx    = ys >> d;
            sx[0] = sx[0] | (|(ys & mask));
        end
        if (x[31] == y[31]) sum = {1'b0, lx} + {1'b0, sx};
        else                sum = {1'b0, lx} - {1'b0, sx};
        e     = $signed({3'b0, x[30:23]});
        lz    = 5'd0;
        found = 1'b0;
        if (sum[27]) begin
            m = sum[27:1] | {26'd0, sum[0]};
            e = e + 11'sd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (sum[i]) found = 1'b1;
                    else        lz    = lz + 5'd1;
                end
            end
            m = sum[26:0] << lz;
            e = e - $signed({6'd0, lz});
        end
        r = {1'b0, m[26:3]} + {24'd0, m[2] & (m[3] | m[1] | m[0])};
        if (r[24]) begin
            r = r >> 1;
            e = e + 11'sd1;
        end
        if (is_nan(a) || is_nan(b) || (a_inf && b_inf && (a[31] != b[31])))
            fp_add = QNAN;
        else if (a_inf)
            fp_add = {a[31], 8'hFF, 23'd0};
        else if (b_inf)
            fp_add = {b[31], 8'hFF, 23'd0};
        else if ((a[30:23] == 8'd0) && (b[30:23] == 8'd0))
            fp_add = {a[31] & b[31], 31'd0};
        else if (a[30:23] == 8'd0)
            fp_add = b;
        else if (b[30:23] == 8'd0)
            fp_add = a;
        else if (sum == 28'd0)
            fp_add = 32'd0;
        else if (e >= 11'sd255)
            fp_add = {x[31], 8'hFF, 23'd0};
        else if (e <= 11'sd0)
            fp_add = {x[31], 31'd0};
        else
            fp_add = {x[31], e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] activate(input logic [31:0] s);
        if (LEAKYRELU_ENABLE && s[31]) activate = fp_mul(ALPHA, s);
        else                           activate = s;
    endfunction

    logic [CNT_W-1:0] beat_cnt;
    logic [31:0]      w_q, d_q, prod_q, acc;
    logic             in_vld, in_first, in_last;
    logic             prod_vld, prod_first, prod_last, acc_done;
    logic [31:0]      prod_next, acc_next, act;

    assign prod_next = fp_mul(w_q, d_q);
    assign acc_next  = prod_first ? prod_q : fp_add(acc, prod_q);
    assign act       = activate(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            w_q        <= '0;
            d_q        <= '0;
            in_vld     <= 1'b0;
            in_first   <= 1'b0;
            in_last    <= 1'b0;
            prod_q     <= '0;
            prod_vld   <= 1'b0;
            prod_first <= 1'b0;
            prod_last  <= 1'b0;
            acc        <= '0;
            acc_done   <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
        end else begin
            in_vld <= i_valid;
            if (i_valid) begin
                w_q      <= i_weight;
                d_q      <= i_data;
                in_first <= (beat_cnt == '0);
                in_last  <= (beat_cnt == LAST_BEAT);
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
            end
            prod_vld  <= in_vld;
            prod_last <= in_vld & in_last;
            if (in_vld) begin
                prod_q     <= prod_next;
                prod_first <= in_first;
            end
            acc_done <= prod_vld & prod_last;
            if (prod_vld) acc <= acc_next;
            o_valid <= acc_done;
            if (acc_done) o_data <= act;
        end
    end

`ifdef FF_NODE_OVERFLOW_FLAG_EN
    // Sticky per-vector flag: any Inf/NaN seen in products, partial sums or the activation.
    logic prod_ovf, acc_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_ovf   <= 1'b0;
            acc_ovf    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (in_vld)   prod_ovf <= (prod_next[30:23] == 8'hFF);
            if (prod_vld) acc_ovf  <= (!prod_first & acc_ovf) | prod_ovf | (acc_next[30:23] == 8'hFF);
            if (acc_done) o_overflow <= acc_ovf | (act[30:23] == 8'hFF);
        end
    end
`endif

endmodule

// File: tb/tb_feed_forward_node_for_input_layer.sv
// Directed bench: three node instances (N=3 with/without LeakyReLU, default N=33).
module tb_feed_forward_node_for_input_layer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v3 = 1'b0, v33 = 1'b0;
    logic [31:0] w = '0, d = '0;
    logic [31:0] od3, od3n, od33;
    logic        ov3, ov3n, ov33;
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          n3 = 0, n3n = 0, n33 = 0;
    logic [31:0] h3[8], h3n[8], h33[8];
    int          t3[8], t3n[8], t33[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    feed_forward_node_for_input_layer #(.NUMBER_OF_INPUT_NODE(3), .LEAKYRELU_ENABLE(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_valid(v3), .i_weight(w), .i_data(d), .o_data(od3), .o_valid(ov3));
    feed_forward_node_for_input_layer #(.NUMBER_OF_INPUT_NODE(3), .LEAKYRELU_ENABLE(1'b0)) dut3n (
        .clk(clk), .rst_n(rst_n), .i_valid(v3), .i_weight(w), .i_data(d), .o_data(od3n), .o_valid(ov3n));
    feed_forward_node_for_input_layer dut33 (
        .clk(clk), .rst_n(rst_n), .i_valid(v33), .i_weight(w), .i_data(d), .o_data(od33), .o_valid(ov33));

    // Record every result strobe with its data and cycle stamp.
    always @(negedge clk) begin
        if (ov3)  begin if (n3 < 8)  begin h3[n3] = od3;    t3[n3] = cyc;   end n3 = n3 + 1;   end
        if (ov3n) begin if (n3n < 8) begin h3n[n3n] = od3n; t3n[n3n] = cyc; end n3n = n3n + 1; end
        if (ov33) begin if (n33 < 8) begin h33[n33] = od33; t33[n33] = cyc; end n33 = n33 + 1; end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic [31:0] wv, input logic [31:0] dv, input logic to33, output int t);
        @(negedge clk);
        w = wv; d = dv; v3 = !to33; v33 = to33;
        t = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v3 = 1'b0; v33 = 1'b0;
        end
    endtask

    task automatic clear_mon;
        n3 = 0; n3n = 0; n33 = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (od3  !== 32'd0) begin errors++; $display("FAIL reset_od3: got %h want 0", od3);   end
        checks++; if (ov3  !== 1'b0)  begin errors++; $display("FAIL reset_ov3: got %b want 0", ov3);   end
        checks++; if (od3n !== 32'd0) begin errors++; $display("FAIL reset_od3n: got %h want 0", od3n); end
        checks++; if (ov3n !== 1'b0)  begin errors++; $display("FAIL reset_ov3n: got %b want 0", ov3n); end
        checks++; if (od33 !== 32'd0) begin errors++; $display("FAIL reset_od33: got %h want 0", od33); end
        checks++; if (ov33 !== 1'b0)  begin errors++; $display("FAIL reset_ov33: got %b want 0", ov33); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int t;
        clear_mon();
        beat(32'h3F800000, 32'h40400000, 1'b0, t);
        beat(32'h40000000, 32'h40800000, 1'b0, t);
        beat(32'h3F000000, 32'h40000000, 1'b0, t);
        idle(6);
        checks++; if (n3 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", n3); end
        checks++; if (h3[0] !== 32'h41400000) begin errors++; $display("FAIL basic_data: got %h want 41400000", h3[0]); end
        checks++; if (t3[0] - t !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", t3[0] - t); end
        checks++; if (n3n !== 1) begin errors++; $display("FAIL basic_pulses_nolr: got %0d want 1", n3n); end
        checks++; if (h3n[0] !== 32'h41400000) begin errors++; $display("FAIL basic_data_nolr: got %h want 41400000", h3n[0]); end
        checks++; if (n33 !== 0) begin errors++; $display("FAIL basic_idle33: got %0d pulses want 0", n33); end
    endtask

    task automatic test_leaky;
        int t;
        clear_mon();
        beat(32'hBF800000, 32'h41200000, 1'b0, t);
        beat(32'h00000000, 32'h00000000, 1'b0, t);
        beat(32'h00000000, 32'h00000000, 1'b0, t);
        idle(6);
        checks++; if (n3 !== 1) begin errors++; $display("FAIL leaky_pulses: got %0d want 1", n3); end
        checks++; if (h3[0] !== 32'hBF800000) begin errors++; $display("FAIL leaky_data: got %h want bf800000", h3[0]); end
        checks++; if (n3n !== 1) begin errors++; $display("FAIL nolr_pulses: got %0d want 1", n3n); end
        checks++; if (h3n[0] !== 32'hC1200000) begin errors++; $display("FAIL nolr_data: got %h want c1200000", h3n[0]); end
        idle(3);
        checks++; if (od3 !== 32'hBF800000) begin errors++; $display("FAIL leaky_hold: got %h want bf800000", od3); end
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL leaky_strobe_low: got %b want 0", ov3); end
    endtask

    task automatic test_gaps;
        int t, t1, t2;
        clear_mon();
        beat(32'h3F800000, 32'h40400000, 1'b0, t);
        idle(2);
        beat(32'h40000000, 32'h40800000, 1'b0, t);
        idle(2);
        beat(32'h3F000000, 32'h40000000, 1'b0, t1);
        beat(32'h3F800000, 32'h3F800000, 1'b0, t);
        beat(32'h3F800000, 32'h3F800000, 1'b0, t);
        beat(32'h3F800000, 32'h3F800000, 1'b0, t2);
        idle(6);
        checks++; if (n3 !== 2) begin errors++; $display("FAIL gaps_pulses: got %0d want 2", n3); end
        checks++; if (h3[0] !== 32'h41400000) begin errors++; $display("FAIL gaps_first: got %h want 41400000", h3[0]); end
        checks++; if (h3[1] !== 32'h40400000) begin errors++; $display("FAIL b2b_second: got %h want 40400000", h3[1]); end
        checks++; if (t3[0] - t1 !== 3) begin errors++; $display("FAIL gaps_latency: got %0d want 3", t3[0] - t1); end
        checks++; if (t3[1] - t2 !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", t3[1] - t2); end
    endtask

    task automatic test_abort;
        int t;
        clear_mon();
        beat(32'h40A00000, 32'h40400000, 1'b0, t);
        beat(32'h40000000, 32'h40800000, 1'b0, t);
        @(negedge clk);
        v3 = 1'b0; rst_n = 1'b0;
        #1;
        checks++; if (od3 !== 32'd0) begin errors++; $display("FAIL abort_reset_data: got %h want 0", od3); end
        @(negedge clk);
        rst_n = 1'b1;
        beat(32'h3F800000, 32'h40400000, 1'b0, t);
        beat(32'h40000000, 32'h40800000, 1'b0, t);
        beat(32'h3F000000, 32'h40000000, 1'b0, t);
        idle(6);
        checks++; if (n3 !== 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", n3); end
        checks++; if (h3[0] !== 32'h41400000) begin errors++; $display("FAIL abort_data: got %h want 41400000", h3[0]); end
    endtask

    task automatic test_special;
        logic [31:0] sw[5][3], sdv[5][3], ex[5];
        int t;
        // overflow, Inf*0, denormal flush, tie-to-even down, tie-to-even up
        sw[0] = '{32'h7F000000, 32'h3F800000, 32'h00000000}; sdv[0] = '{32'h40000000, 32'h3F800000, 32'h00000000}; ex[0] = 32'h7F800000;
        sw[1] = '{32'h7F800000, 32'h3F800000, 32'h3F800000}; sdv[1] = '{32'h00000000, 32'h3F800000, 32'h3F800000}; ex[1] = 32'h7FC00000;
        sw[2] = '{32'h00400000, 32'h3F800000, 32'h00000000}; sdv[2] = '{32'h3F800000, 32'h3F800000, 32'h00000000}; ex[2] = 32'h3F800000;
        sw[3] = '{32'h3F800000, 32'h33800000, 32'h00000000}; sdv[3] = '{32'h3F800000, 32'h3F800000, 32'h00000000}; ex[3] = 32'h3F800000;
        sw[4] = '{32'h3F800001, 32'h33800000, 32'h00000000}; sdv[4] = '{32'h3F800000, 32'h3F800000, 32'h00000000}; ex[4] = 32'h3F800002;
        clear_mon();
        for (int v = 0; v < 5; v++)
            for (int b = 0; b < 3; b++)
                beat(sw[v][b], sdv[v][b], 1'b0, t);
        idle(6);
        checks++; if (n3 !== 5) begin errors++; $display("FAIL special_pulses: got %0d want 5", n3); end
        for (int v = 0; v < 5; v++) begin
            checks++;
            if (h3[v] !== ex[v]) begin errors++; $display("FAIL special_%0d: got %h want %h", v, h3[v], ex[v]); end
            checks++;
            if (h3n[v] !== ex[v]) begin errors++; $display("FAIL special_nolr_%0d: got %h want %h", v, h3n[v], ex[v]); end
        end
    endtask

    task automatic test_default;
        int t;
        clear_mon();
        for (int i = 0; i < 33; i++) beat(32'h40000000, 32'h3F000000, 1'b1, t);
        idle(6);
        checks++; if (n33 !== 1) begin errors++; $display("FAIL default_pulses: got %0d want 1", n33); end
        checks++; if (h33[0] !== 32'h42040000) begin errors++; $display("FAIL default_data: got %h want 42040000", h33[0]); end
        checks++; if (t33[0] - t !== 3) begin errors++; $display("FAIL default_latency: got %0d want 3", t33[0] - t); end
        checks++; if (n3 !== 0) begin errors++; $display("FAIL default_isolation: got %0d pulses want 0", n3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_leaky();
        test_gaps();
        test_abort();
        test_special();
        test_default();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
